// File: rtl/pc_mem_block_if.sv
// rtl/pc_mem_block_if.sv - control strobes and shared-bus signals between sequencer and pc_mem_block
interface pc_mem_block_if;
  logic       pc_inc;
  logic       pc_en;
  logic       pc_load;
  logic       mar_load_n;
  logic       mdr_load_n;
  logic       ram_en_n;
  logic       ram_load_n;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic       bus_oe;

  // Sequencer side: issues strobes and presents the bus value
  modport master (
    output pc_inc, pc_en, pc_load, mar_load_n, mdr_load_n, ram_en_n, ram_load_n, bus_in,
    input  bus_out, bus_oe
  );

  // Memory block side: samples strobes and drives its bus contribution
  modport slave (
    input  pc_inc, pc_en, pc_load, mar_load_n, mdr_load_n, ram_en_n, ram_load_n, bus_in,
    output bus_out, bus_oe
  );
endinterface

// File: rtl/pc_mem_block.sv
// rtl/pc_mem_block.sv - PC, MAR, MDR and 16x8 RAM for SAP CPU; optional programming port via PC_MEM_PROG_EN
module pc_mem_block (
  input  logic          clk,
  input  logic          rst_n,
  pc_mem_block_if.slave bus,
  output logic          bus_conflict,
  output logic [3:0]    pc_q,
  output logic [3:0]    mar_q,
  input  logic          prog_en,
  input  logic          prog_we,
  input  logic [3:0]    prog_addr,
  input  logic [7:0]    prog_data
);

  logic [3:0] pc;
  logic [3:0] mar;
  logic [7:0] mdr;
  logic       conflict;
  logic [7:0] ram [16];
  logic [7:0] rd_data;
  logic       core_act;

`ifdef PC_MEM_PROG_EN
  // Programming mode masks every core strobe
  assign core_act = ~prog_en;
`else
  logic unused_prog;
  assign core_act    = 1'b1;
  assign unused_prog = ^{prog_en, prog_we, prog_addr, prog_data};
`endif

  // PC, MAR, MDR and sticky conflict flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= 4'h0;
      mar      <= 4'h0;
      mdr      <= 8'h00;
      conflict <= 1'b0;
    end else if (core_act) begin
      if (bus.pc_load)
        pc <= bus.bus_in[3:0];
      else if (bus.pc_inc)
        pc <= pc + 4'h1;
      if (!bus.mar_load_n)
        mar <= bus.bus_in[3:0];
      if (!bus.mdr_load_n)
        mdr <= bus.bus_in;
      if (bus.pc_en && !bus.ram_en_n)
        conflict <= 1'b1;
    end
  end

  // RAM array: cleared on reset, written from pre-edge MAR/MDR or the programming port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++)
        ram[i] <= 8'h00;
    end else begin
      if (core_act && !bus.ram_load_n)
        ram[mar] <= mdr;
`ifdef PC_MEM_PROG_EN
      if (prog_en && prog_we)
        ram[prog_addr] <= prog_data;
`endif
    end
  end

  assign rd_data = ram[mar];

  // Bus drive: RAM wins over PC; silent during reset and programming mode
  always_comb begin
    bus.bus_oe  = 1'b0;
    bus.bus_out = 8'h00;
    if (rst_n && core_act) begin
      bus.bus_oe = bus.pc_en | ~bus.ram_en_n;
      if (!bus.ram_en_n)
        bus.bus_out = rd_data;
      else if (bus.pc_en)
        bus.bus_out = {4'h0, pc};
    end
  end

  assign bus_conflict = conflict;
  assign pc_q         = pc;
  assign mar_q        = mar;

endmodule
